// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_reg: valid/ready pipeline latch with optional 2-entry skid     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 2,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic              w_main_valid;

   // Control bits are gated so a bubble can never assert a write downstream.
   assign out_data  = r_main_data;
   assign out_valid = w_main_valid;
   assign out_ctrl  = w_main_valid ? r_main_ctrl : '0;

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_FULL  = 2'd2
         } state_t;

         state_t            r_state;
         state_t            w_next;
         logic              r_in_ready;
         logic [DATA_W-1:0] r_skid_data;
         logic [CTRL_W-1:0] r_skid_ctrl;
         logic              w_accept;
         logic              w_deliver;
         logic              w_load_in;
         logic              w_load_skid;
         logic              w_promote;

         assign in_ready     = r_in_ready;
         assign w_main_valid = (r_state != ST_EMPTY);
         assign occupancy    = r_state;

         always_comb begin
            w_next      = r_state;
            w_load_in   = 1'b0;
            w_load_skid = 1'b0;
            w_promote   = 1'b0;
            w_accept    = in_valid & r_in_ready;
            w_deliver   = (r_state != ST_EMPTY) & out_ready;
            case (r_state)
               ST_EMPTY: begin
                  if (w_accept) begin
                     w_next    = ST_ONE;
                     w_load_in = 1'b1;
                  end
               end
               ST_ONE: begin
                  if (w_accept && !w_deliver) begin
                     w_next      = ST_FULL;
                     w_load_skid = 1'b1;
                  end else if (w_accept) begin
                     w_load_in = 1'b1;
                  end else if (w_deliver) begin
                     w_next = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (w_deliver) begin
                     w_next    = ST_ONE;
                     w_promote = 1'b1;
                  end
               end
               default: w_next = ST_EMPTY;
            endcase
         end

         // in_ready is precomputed from the next state so it leaves a flop.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_state    <= ST_EMPTY;
               r_in_ready <= 1'b1;
            end else if (flush) begin
               r_state    <= ST_EMPTY;
               r_in_ready <= 1'b1;
            end else begin
               r_state    <= w_next;
               r_in_ready <= (w_next != ST_FULL);
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_main_data <= '0;
               r_main_ctrl <= '0;
               r_skid_data <= '0;
               r_skid_ctrl <= '0;
            end else if (flush) begin
               r_main_data <= '0;
               r_main_ctrl <= '0;
               r_skid_data <= '0;
               r_skid_ctrl <= '0;
            end else begin
               if (w_load_in) begin
                  r_main_data <= in_data;
                  r_main_ctrl <= in_ctrl;
               end else if (w_promote) begin
                  r_main_data <= r_skid_data;
                  r_main_ctrl <= r_skid_ctrl;
               end
               if (w_load_skid) begin
                  r_skid_data <= in_data;
                  r_skid_ctrl <= in_ctrl;
               end
            end
         end
      end else begin : g_single
         logic r_valid;

         assign in_ready     = out_ready | ~r_valid;
         assign w_main_valid = r_valid;
         assign occupancy    = {1'b0, r_valid};

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_valid     <= 1'b0;
               r_main_data <= '0;
               r_main_ctrl <= '0;
            end else if (flush) begin
               r_valid     <= 1'b0;
               r_main_data <= '0;
               r_main_ctrl <= '0;
            end else if (in_valid && in_ready) begin
               r_valid     <= 1'b1;
               r_main_data <= in_data;
               r_main_ctrl <= in_ctrl;
            end else if (out_ready) begin
               r_valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_reg: queue-model scoreboard for both SKID variants         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;
   localparam int DW = 69;
   localparam int CW = 2;
   localparam logic [DW-1:0] T1_DATA = 69'h0_A5A5_A5A5_A5A5_A501;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;

   logic          rdy1, vld1, rdy0, vld0;
   logic [DW-1:0] dat1, dat0;
   logic [CW-1:0] ctl1, ctl0;
   logic [1:0]    occ1, occ0;

   int            n_vec = 0;
   int            n_err = 0;

   // Reference: each stage is a bounded FIFO plus the last value it showed.
   ent_t          q1[$];
   ent_t          q0[$];
   logic [DW-1:0] last1 = '0;
   logic [DW-1:0] last0 = '0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .out_ctrl(ctl1),
      .occupancy(occ1)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .out_ctrl(ctl0),
      .occupancy(occ0)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus side: record what each stage should have accepted and delivered.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q1.delete();
         q0.delete();
         last1 = '0;
         last0 = '0;
      end else begin
         logic a1, d1, a0, d0;
         ent_t e;
         a1 = in_valid && (q1.size() < 2);
         d1 = (q1.size() != 0) && out_ready;
         a0 = in_valid && (out_ready || q0.size() == 0);
         d0 = (q0.size() != 0) && out_ready;
         e.d = in_data;
         e.c = in_ctrl;
         if (flush) begin
            q1.delete();
            q0.delete();
            last1 = '0;
            last0 = '0;
         end else begin
            if (d1) begin
               ent_t p;
               p = q1.pop_front();
               last1 = p.d;
            end
            if (a1) q1.push_back(e);
            if (d0) begin
               ent_t p;
               p = q0.pop_front();
               last0 = p.d;
            end
            if (a0) q0.push_back(e);
         end
      end
   end

   // Monitor: compare whatever each DUT presents with the head of its queue.
   always @(negedge clk) begin
      chk("skid_valid", vld1, q1.size() != 0);
      chk("skid_occupancy", occ1, q1.size());
      chk("skid_in_ready", rdy1, q1.size() < 2);
      chk("skid_ctrl", ctl1, (q1.size() != 0) ? q1[0].c : '0);
      chk("skid_data", dat1, (q1.size() != 0) ? q1[0].d : last1);
      chk("single_valid", vld0, q0.size() != 0);
      chk("single_occupancy", occ0, q0.size());
      chk("single_in_ready", rdy0, out_ready || q0.size() == 0);
      chk("single_ctrl", ctl0, (q0.size() != 0) ? q0[0].c : '0);
      chk("single_data", dat0, (q0.size() != 0) ? q0[0].d : last0);
   end

   task automatic cyc(input logic v, input logic r, input logic f);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_data   = DW'({$urandom(), $urandom(), $urandom()});
      in_ctrl   = CW'($urandom());
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Single entry with 1-cycle latency
      in_valid  = 1'b1;
      in_data   = T1_DATA;
      in_ctrl   = 2'b11;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t1_valid", vld1, 1'b1);
      chk("t1_data", dat1, T1_DATA);
      chk("t1_ctrl", ctl1, 2'b11);
      chk("t1_occupancy", occ1, 2'd1);
      cyc(1'b0, 1'b1, 1'b0);

      // Back-to-back stream
      repeat (8) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);

      // Backpressure fills the skid, then drains in order
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      chk("t3_occupancy", occ1, 2'd2);
      chk("t3_in_ready", rdy1, 1'b0);
      repeat (3) cyc(1'b1, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0);

      // Bubbles keep ctrl clean even with ctrl held high on the input
      repeat (3) begin
         in_valid  = 1'b0;
         out_ready = 1'b1;
         in_ctrl   = 2'b11;
         @(posedge clk);
         #1;
      end
      chk("t4_ctrl", ctl1, 2'b00);

      // Flush while full with a new entry offered
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("t5_occupancy", occ1, 2'd0);
      chk("t5_valid", vld1, 1'b0);
      chk("t5_ctrl", ctl1, 2'b00);
      chk("t5_data", dat1, '0);
      chk("t5_in_ready", rdy1, 1'b1);
      repeat (2) cyc(1'b0, 1'b1, 1'b0);

      // Asynchronous reset between edges
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_valid", vld1, 1'b0);
      chk("t6_occupancy", occ1, 2'd0);
      chk("t6_data", dat1, '0);
      chk("t6_ctrl", ctl1, 2'b00);
      chk("t6_in_ready", rdy1, 1'b1);
      chk("t6_single_valid", vld0, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      chk("t6_latency", vld1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);

      // Randomized traffic with occasional flushes
      repeat (600)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      cyc(1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
